// File: rtl/adder_acc.sv
// Windowed accumulator downstream of adder: sums WINDOW qualified samples and presents the total one edge later.
// Upstream never stalls; a completed window finding the output register still occupied is dropped and flagged in oOvf.
module adder_acc #(
  parameter int BITWIDTH = 32,
  parameter int WINDOW   = 256
) (
  input  logic                                   iClk,
  input  logic                                   iRstN,
  input  logic                                   iEn,
  input  logic                                   iClr,
  input  logic [BITWIDTH:0]                      iData,
  input  logic                                   iReady,
  output logic                                   oValid,
  output logic [BITWIDTH+((WINDOW > 1) ? $clog2(WINDOW) : 1):0] oData,
  output logic                                   oOvf,
  output logic [((WINDOW > 1) ? $clog2(WINDOW) : 1)-1:0] oCount
);

  localparam int CNTW     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int ACCWIDTH = BITWIDTH + 1 + CNTW;
  localparam logic [CNTW-1:0] LAST = CNTW'(WINDOW - 1);

  logic [ACCWIDTH-1:0] acc_q, acc_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [ACCWIDTH-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;

  logic [ACCWIDTH-1:0] sum;
  logic                complete;
  logic                out_free;

  // The output register is free if empty or being drained this very cycle.
  always_comb begin
    sum      = acc_q + ACCWIDTH'(iData);
    complete = iEn && (cnt_q == LAST);
    out_free = !valid_q || iReady;

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    if (iEn) begin
      if (complete) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (complete) begin
      if (out_free) begin
        data_d  = sum;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && iReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN || iClr) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oValid = valid_q;
  assign oData  = data_q;
  assign oOvf   = ovf_q;
  assign oCount = cnt_q;

endmodule

// File: tb/tb_adder_acc.sv
// Randomized and directed check of adder_acc against a queue-based window model.
module tb_adder_acc;

  localparam int BW   = 32;
  localparam int WIN  = 4;
  localparam int CW   = 2;
  localparam int AW   = BW + 1 + CW;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic [BW:0]   din;
  logic          rdy;
  logic          vld;
  logic [AW-1:0] dout;
  logic          ovf;
  logic [CW-1:0] cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: samples of the open window, plus the output slot.
  logic [BW:0]   m_win[$];
  logic          m_vld;
  logic [AW-1:0] m_dat;
  logic          m_ovf;

  adder_acc #(.BITWIDTH(BW), .WINDOW(WIN)) dut (
    .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr), .iData(din),
    .iReady(rdy), .oValid(vld), .oData(dout), .oOvf(ovf), .oCount(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r_n, input logic c, input logic e,
                            input logic [BW:0] d, input logic r);
    longint unsigned s;
    logic done;
    if (!r_n || c) begin
      m_win.delete();
      m_vld = 1'b0;
      m_dat = '0;
      m_ovf = 1'b0;
    end else begin
      done = 1'b0;
      s = 0;
      if (e) begin
        m_win.push_back(d);
        if (m_win.size() == WIN) begin
          foreach (m_win[i]) s += longint'(m_win[i]);
          m_win.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!m_vld || r) begin
          m_dat = AW'(s);
          m_vld = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_vld && r) begin
        m_vld = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic cyc(input logic e, input logic [BW:0] d, input logic r,
                     input logic c = 1'b0, input logic r_n = 1'b1);
    en = e; din = d; rdy = r; clr = c; rst_n = r_n;
    @(posedge clk);
    model_step(r_n, c, e, d, r);
    #1;
    check_eq("valid", 64'(vld), 64'(m_vld));
    check_eq("data",  64'(dout), 64'(m_dat));
    check_eq("ovf",   64'(ovf), 64'(m_ovf));
    check_eq("count", 64'(cnt), 64'(m_win.size()));
  endtask

  initial begin
    logic [BW:0] rd;
    en = 1'b0; din = '0; rdy = 1'b0; clr = 1'b0; rst_n = 1'b0;
    m_vld = 1'b0; m_dat = '0; m_ovf = 1'b0;

    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check_eq("rst_valid", 64'(vld), 64'd0);
    check_eq("rst_data",  64'(dout), 64'd0);
    check_eq("rst_ovf",   64'(ovf), 64'd0);
    check_eq("rst_count", 64'(cnt), 64'd0);

    // Basic window of 30s.
    for (int i = 0; i < 4; i++) cyc(1, 30, 1);
    check_eq("basic_valid", 64'(vld), 64'd1);
    check_eq("basic_data",  64'(dout), 64'd120);
    cyc(0, 0, 1);
    check_eq("basic_drop",  64'(vld), 64'd0);
    check_eq("basic_hold",  64'(dout), 64'd120);

    // Gaps between qualified samples.
    for (int i = 1; i <= 4; i++) begin
      cyc(1, BW'(i), 1);
      check_eq("gap_count", 64'(cnt), 64'(i % 4));
      cyc(0, 33'h1_2345_6789, 1);
    end
    check_eq("gap_data", 64'(dout), 64'd10);

    // Max operands, no wrap.
    for (int i = 0; i < 4; i++) cyc(1, {(BW+1){1'b1}}, 1);
    check_eq("max_data", 64'(dout), (64'd1 << 35) - 64'd4);
    cyc(0, 0, 1);

    // Backpressure: second window is dropped.
    for (int i = 0; i < 4; i++) cyc(1, 5, 0);
    check_eq("bp_valid1", 64'(vld), 64'd1);
    check_eq("bp_data1",  64'(dout), 64'd20);
    for (int i = 0; i < 4; i++) cyc(1, 5, 0);
    check_eq("bp_ovf",    64'(ovf), 64'd1);
    check_eq("bp_data2",  64'(dout), 64'd20);
    cyc(0, 0, 1);
    check_eq("bp_taken",  64'(vld), 64'd0);
    check_eq("bp_sticky", 64'(ovf), 64'd1);
    cyc(0, 0, 1);
    check_eq("bp_sticky2", 64'(ovf), 64'd1);
    cyc(0, 0, 0, 1);
    check_eq("clr_ovf", 64'(ovf), 64'd0);

    // Completion coinciding with a handshake.
    for (int i = 0; i < 4; i++) cyc(1, 3, 0);
    check_eq("sim_pre", 64'(dout), 64'd12);
    for (int i = 0; i < 3; i++) cyc(1, 7, 0);
    cyc(1, 7, 1);
    check_eq("sim_data",  64'(dout), 64'd28);
    check_eq("sim_valid", 64'(vld), 64'd1);
    check_eq("sim_ovf",   64'(ovf), 64'd0);
    cyc(0, 0, 1);

    // Clear mid-window discards partial sum and the sample presented with it.
    cyc(1, 9, 1);
    cyc(1, 9, 1);
    cyc(1, 9, 1, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1);
    check_eq("clr_data", 64'(dout), 64'd4);

    // Reset mid-window.
    cyc(1, 9, 0);
    cyc(1, 9, 0);
    cyc(1, 9, 0, 0, 0);
    check_eq("rstm_valid", 64'(vld), 64'd0);
    check_eq("rstm_data",  64'(dout), 64'd0);
    check_eq("rstm_count", 64'(cnt), 64'd0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1);
    check_eq("rstm_next", 64'(dout), 64'd4);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      rd = {1'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) rd = {(BW+1){1'b1}};
      cyc(1'($urandom_range(0, 3) != 0), rd, 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 149) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
